// File: rtl/ddr3_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_arb_pkg
//  Purpose  : Shared types and constants for the two-port DDR3 app arbiter.
//             - arb_state_t : command sequencer states
//             - CMD_WR/CMD_RD : app_cmd encodings
//             - ADDR_STEP_DEFAULT : address advance per accepted BL8 command
//             - ADDR_WRAP_W : width of the wrapping burst address
//  Revision : 1.0  initial release
// ============================================================================
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        WAIT_CAL = 2'd0,
        ARB      = 2'd1,
        BURST    = 2'd2
    } arb_state_t;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    localparam int ADDR_STEP_DEFAULT = 8;

    // Burst addresses advance modulo 2^25; upper app_addr bits are forced 0.
    localparam int ADDR_WRAP_W = 25;

endpackage
`default_nettype wire

// File: rtl/ddr3_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_arb_tag_fifo
//  Purpose  : In-order FIFO of 1-bit port tags, one entry per issued read
//             command. Head entry is visible on o_pop_tag (first-word
//             fall-through). Push and pop in the same cycle are both taken.
//  Ports    : ui_clk, rst_n (async, active-low)
//             i_push/i_push_tag : enqueue a tag (ignored when full)
//             i_pop             : dequeue head (ignored when empty)
//             o_pop_tag         : head tag
//             o_full/o_empty    : occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module ddr3_arb_tag_fifo #(
    parameter int DEPTH = 64
) (
    input  logic ui_clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_push_tag,
    input  logic i_pop,
    output logic o_pop_tag,
    output logic o_full,
    output logic o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign o_pop_tag = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_PTR_W-1:0]] <= i_push_tag;
                r_wr_ptr                     <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr3_app_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_app_arbiter
//  Purpose  : Two-port round-robin burst scheduler in front of a DDR3
//             controller app_* interface. Sequences app_en/app_cmd/app_addr
//             and app_wdf_* under app_rdy/app_wdf_rdy back-pressure and
//             routes read data back to the issuing port via a tag FIFO.
//  Ports    : ui_clk, rst_n (async, active-low), init_calib_complete
//             app_*   : controller user interface
//             pN_*    : per-port burst request / write data / read return
//             rd_data : registered read data shared by both ports
//             tag_err : sticky, read data arrived with no outstanding read
//  Revision : 1.0  initial release
// ============================================================================
module ddr3_app_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int TAG_DEPTH = 64,
    parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              init_calib_complete,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic              app_rd_data_valid,
    input  logic [DATA_W-1:0] app_rd_data,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    output logic [DATA_W-1:0] app_wdf_data,
    input  logic              p0_req,
    input  logic              p0_cmd,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [7:0]        p0_len,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_wdata_rd,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic              p0_rd_valid,
    input  logic              p1_req,
    input  logic              p1_cmd,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [7:0]        p1_len,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_wdata_rd,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic              p1_rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              tag_err
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;

    logic                   r_cmd_rd;
    logic                   r_port;
    logic                   r_last;      // port granted most recently
    logic [ADDR_WRAP_W-1:0] r_addr;
    logic [7:0]             r_len;
    logic [7:0]             r_cnt;

    logic                   w_any_req;
    logic                   w_pick;
    logic                   w_sel_cmd;
    logic [ADDR_WRAP_W-1:0] w_sel_addr;
    logic [7:0]             w_sel_len;
    logic                   w_in_burst;
    logic                   w_accept;
    logic                   w_wr_accept;
    logic                   w_last_beat;
    logic                   w_load;
    logic [1:0]             w_gnt;
    logic [1:0]             w_done;

    logic                   w_tag_full;
    logic                   w_tag_empty;
    logic                   w_tag_out;

    logic [1:0]             r_rd_valid;
    logic [DATA_W-1:0]      r_rd_data;
    logic                   r_tag_err;

    logic                   w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, p0_addr[ADDR_W-1:ADDR_WRAP_W],
                                        p1_addr[ADDR_W-1:ADDR_WRAP_W]};

    // ------------------------------------------------------------------
    // Arbitration: on contention the port not granted last wins.
    // ------------------------------------------------------------------
    assign w_any_req  = p0_req | p1_req;
    assign w_pick     = (p0_req & p1_req) ? ~r_last : p1_req;
    assign w_sel_cmd  = w_pick ? p1_cmd : p0_cmd;
    assign w_sel_addr = w_pick ? p1_addr[ADDR_WRAP_W-1:0] : p0_addr[ADDR_WRAP_W-1:0];
    assign w_sel_len  = w_pick ? p1_len : p0_len;

    // ------------------------------------------------------------------
    // Command handshake. Reads also need room to record their tag.
    // ------------------------------------------------------------------
    assign w_in_burst  = (r_state == BURST);
    assign w_accept    = w_in_burst & app_rdy & (r_cmd_rd ? ~w_tag_full : app_wdf_rdy);
    assign w_wr_accept = w_accept & ~r_cmd_rd;
    assign w_last_beat = w_accept & (r_cnt == (r_len - 8'd1));

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_CAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        w_done      = 2'b00;
        w_load      = 1'b0;
        case (r_state)
            WAIT_CAL: begin
                if (init_calib_complete) begin
                    w_state_nxt = ARB;
                end
            end
            ARB: begin
                if (w_any_req) begin
                    w_gnt[w_pick] = 1'b1;
                    w_load        = 1'b1;
                    // Zero-length bursts complete on the spot.
                    if (w_sel_len == 8'd0) begin
                        w_done[w_pick] = 1'b1;
                    end else begin
                        w_state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                if (w_last_beat) begin
                    w_done[r_port] = 1'b1;
                    w_state_nxt    = ARB;
                end
            end
            default: begin
                w_state_nxt = WAIT_CAL;
            end
        endcase
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_rd <= 1'b0;
            r_port   <= 1'b0;
            r_last   <= 1'b1;   // makes p0 the first winner
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_cmd_rd <= w_sel_cmd;
            r_addr   <= w_sel_addr;
            r_len    <= w_sel_len;
            r_cnt    <= '0;
            r_port   <= w_pick;
            if (w_sel_len == 8'd0) begin
                r_last <= w_pick;
            end
        end else if (w_accept) begin
            r_addr <= r_addr + ADDR_WRAP_W'(ADDR_STEP);
            r_cnt  <= r_cnt + 8'd1;
            if (w_last_beat) begin
                r_last <= r_port;
            end
        end
    end

    // ------------------------------------------------------------------
    // App interface outputs; everything is forced to 0 outside BURST.
    // ------------------------------------------------------------------
    always_comb begin
        app_addr = '0;
        if (w_in_burst) begin
            app_addr[ADDR_WRAP_W-1:0] = r_addr;
        end
    end

    assign app_en       = w_accept;
    assign app_cmd      = (w_in_burst && r_cmd_rd) ? CMD_RD : CMD_WR;
    assign app_wdf_wren = w_wr_accept;
    assign app_wdf_end  = w_wr_accept;
    assign app_wdf_data = w_in_burst ? (r_port ? p1_wdata : p0_wdata) : '0;
    assign p0_wdata_rd  = w_wr_accept & ~r_port;
    assign p1_wdata_rd  = w_wr_accept &  r_port;
    assign p0_gnt       = w_gnt[0];
    assign p1_gnt       = w_gnt[1];
    assign p0_done      = w_done[0];
    assign p1_done      = w_done[1];

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------
    ddr3_arb_tag_fifo #(
        .DEPTH      (TAG_DEPTH)
    ) u_tag_fifo (
        .ui_clk     (ui_clk),
        .rst_n      (rst_n),
        .i_push     (w_accept & r_cmd_rd),
        .i_push_tag (r_port),
        .i_pop      (app_rd_data_valid),
        .o_pop_tag  (w_tag_out),
        .o_full     (w_tag_full),
        .o_empty    (w_tag_empty)
    );

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 2'b00;
            r_rd_data  <= '0;
            r_tag_err  <= 1'b0;
        end else begin
            r_rd_valid <= 2'b00;
            if (app_rd_data_valid) begin
                r_rd_data <= app_rd_data;
                if (w_tag_empty) begin
                    r_tag_err <= 1'b1;
                end else begin
                    r_rd_valid[w_tag_out] <= 1'b1;
                end
            end
        end
    end

    assign p0_rd_valid = r_rd_valid[0];
    assign p1_rd_valid = r_rd_valid[1];
    assign rd_data     = r_rd_data;
    assign tag_err     = r_tag_err;

endmodule
`default_nettype wire

// File: doc/ddr3_app_arbiter.md
Name: ddr3_app_arbiter

Overview:
- Two-port scheduler in front of the DDR3 controller user (app_*) interface, ui_clk domain.
- Each port issues burst requests (read or write, start address, burst count). The arbiter grants bursts round-robin, then sequences app_en/app_cmd/app_addr and app_wdf_* with full app_rdy/app_wdf_rdy back-pressure.
- Read return data is routed back to the issuing port through an in-order tag FIFO.
- Replaces per-adapter ad-hoc sequencing when two frame/packet adapters share one DDR3.

Parameters:
- ADDR_W, 28, app_addr width.
- DATA_W, 128, app data width.
- TAG_DEPTH, 64, outstanding read commands trackable (power of 2).
- ADDR_STEP, 8, address increment per accepted command (BL8).

Ports:
- ui_clk  in  1  controller user clock
- rst_n  in  1  reset
- init_calib_complete  in  1  DDR3 calibration done
- app_rdy  in  1  controller command ready
- app_wdf_rdy  in  1  controller write-data ready
- app_rd_data_valid  in  1  read data valid
- app_rd_data  in  DATA_W  read data
- app_en  out  1  command strobe
- app_cmd  out  3  0 = write, 1 = read
- app_addr  out  ADDR_W  {3'b0, addr[24:0]}
- app_wdf_wren  out  1  write-data strobe
- app_wdf_end  out  1  equals app_wdf_wren
- app_wdf_data  out  DATA_W  granted port's write data
- pN_req  in  1  burst request, N = 0,1; held until pN_done
- pN_cmd  in  1  0 = write, 1 = read
- pN_addr  in  ADDR_W  burst start address
- pN_len  in  8  number of commands in burst
- pN_wdata  in  DATA_W  FWFT write data
- pN_wdata_rd  out  1  pop pulse for pN_wdata
- pN_gnt  out  1  one-cycle pulse when burst latched
- pN_done  out  1  one-cycle pulse after last command accepted
- pN_rd_valid  out  1  read beat for port N
- rd_data  out  DATA_W  app_rd_data, registered
- tag_err  out  1  sticky: read data returned with tag FIFO empty

Behaviour:
- Reset: all outputs 0, state WAIT_CAL, round-robin priority on p0, tag FIFO empty, tag_err cleared.
- Only rst_n clears tag_err.
- WAIT_CAL -> ARB when init_calib_complete = 1. The signal is ignored after that.
- ARB arbitration:
  - Picks a requesting port. If both request, the port not granted last wins; p0 wins first after reset.
  - Latches cmd/addr/len/port, pulses pN_gnt, goes to BURST next cycle.
  - ARB has a single-cycle dwell per burst, so there is a minimum 1-cycle bubble between bursts.
  - If len = 0: pulse gnt and done in the same cycle, issue no commands, stay in ARB with priority rotated.
- BURST, write burst:
  - accept = app_rdy & app_wdf_rdy.
  - app_en, app_wdf_wren, app_wdf_end and pN_wdata_rd all equal accept (combinational). app_cmd = 0.
- BURST, read burst:
  - accept = app_rdy & !tag_full.
  - app_en = accept, app_cmd = 1.
  - Each accept pushes the port id into the tag FIFO.
- BURST, common rules:
  - app_addr is driven from the burst address register in every BURST cycle, including stalled ones.
  - On accept: address += ADDR_STEP, wrapping modulo 2^25; count++.
  - On accept with count = len-1: pulse pN_done, rotate priority, go to ARB.
  - Without accept, all registers hold.
- Outside BURST: app_en, app_wdf_wren and pN_wdata_rd are 0. app_cmd/app_addr are don't-care.
- Request handling:
  - pN_req deassert mid-burst is ignored; the burst completes.
  - Request inputs are only sampled in ARB.
- Read return:
  - On app_rd_data_valid, pop the tag. Next cycle, assert rd_data and the pN_rd_valid for that tag (1-cycle latency).
  - Pop and push in the same cycle are both honoured and occupancy is unchanged.
  - app_rd_data_valid with the FIFO empty sets tag_err and asserts no pN_rd_valid.
- Read return is independent of the command state machine: writes may be issued while reads are still outstanding.

Decomposition:
- Package ddr3_arb_pkg:
  - state encoding WAIT_CAL/ARB/BURST
  - CMD_WR = 3'd0, CMD_RD = 3'd1
  - ADDR_STEP default
- Sub-module ddr3_arb_tag_fifo: synchronous, TAG_DEPTH x 1 bit, push/pop/full/empty, simultaneous push/pop supported.

Test Plan:
- p0 write, addr 0x100, len 4, app_rdy = app_wdf_rdy = 1 -> app_en for 4 consecutive cycles at addr 0x100/0x108/0x110/0x118; 4 p0_wdata_rd pulses; p0_done pulses in the cycle of the 4th accept.
- p0 and p1 requesting continuously, len 2 each -> grants alternate p0, p1, p0, p1 with a 1-cycle bubble between bursts.
- p1 read, len 3, app_rdy low for 5 cycles mid-burst -> app_addr held and no app_en while stalled; exactly 3 accepts; tags [1,1,1]; 3 returned beats appear only on p1_rd_valid.
- Interleave: p0 read len 2, then p1 read len 2 -> 4 returned beats routed p0, p0, p1, p1; tag_err stays 0.
- Inject app_rd_data_valid with no outstanding reads -> tag_err = 1 and stays 1; no pN_rd_valid asserted.
- Boundary and reset cases:
  - addr 0x1FFFFF8, len 2 -> second command at 0x0000000.
  - len 0 -> gnt and done in the same cycle, no app_en.
  - rst_n asserted mid-burst -> all outputs 0 immediately, state WAIT_CAL.
